// File: rtl/ysyx_22041211_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter and access sequencer for the single-port SRAM.
// Latency: request handshake -> LATENCY SRAM cycles -> response from handshake + LATENCY + 1.
// Backpressure: one transaction in flight; req_ready only in IDLE, RESP holds until resp_ready.
//
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   ifu_req_* / ifu_addr              IFU fetch request (always a 4-byte read, mask 8'h0F)
//   ifu_resp_* / ifu_rdata            IFU fetch response
//   lsu_req_* / lsu_wen/addr/wdata/mask   LSU load/store request
//   lsu_resp_* / lsu_rdata            LSU response (rdata = 0 for store acks)
//   sram_*                            SRAM port, driven only during ACCESS
//
// Build option: define ARB_RR_EN for round-robin arbitration on simultaneous
// requests; otherwise LSU has fixed priority over IFU.
module ysyx_22041211_mem_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int LATENCY  = 1
) (
  input  logic                clk,
  input  logic                rstn,
  // IFU request / response
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_LEN-1:0] ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_LEN-1:0] ifu_rdata,
  // LSU request / response
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_LEN-1:0] lsu_addr,
  input  logic [DATA_LEN-1:0] lsu_wdata,
  input  logic [7:0]          lsu_mask,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_LEN-1:0] lsu_rdata,
  // SRAM port
  output logic                sram_ren,
  output logic                sram_wen,
  output logic [ADDR_LEN-1:0] sram_raddr,
  output logic [ADDR_LEN-1:0] sram_waddr,
  output logic [DATA_LEN-1:0] sram_wdata,
  output logic [7:0]          sram_rmask,
  output logic [7:0]          sram_wmask,
  input  logic [DATA_LEN-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic       OWN_IFU  = 1'b0;
  localparam logic       OWN_LSU  = 1'b1;
  localparam logic [7:0] IFU_MASK = 8'h0F;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t                state;
  state_t                state_nxt;

  // Latched transaction
  logic                  owner;
  logic                  wen_q;
  logic [ADDR_LEN-1:0]   addr_q;
  logic [DATA_LEN-1:0]   wdata_q;
  logic [7:0]            mask_q;
  logic [7:0]            cnt;

  logic                  grant_lsu;
  logic                  ifu_hs;
  logic                  lsu_hs;
  logic                  resp_hs;
  logic                  last_cycle;

`ifdef ARB_RR_EN
  logic                  last_grant;
`endif

  assign ifu_hs     = ifu_req_valid & ifu_req_ready;
  assign lsu_hs     = lsu_req_valid & lsu_req_ready;
  assign resp_hs    = (ifu_resp_valid & ifu_resp_ready) | (lsu_resp_valid & lsu_resp_ready);
  assign last_cycle = (cnt == 8'd0);

  // Arbitration: only matters when both masters request together.
  always_comb begin
    grant_lsu = lsu_req_valid;
    if (lsu_req_valid && ifu_req_valid) begin
`ifdef ARB_RR_EN
      // The master that did not win the previous grant goes first.
      grant_lsu = (last_grant == OWN_IFU);
`else
      grant_lsu = 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ifu_hs || lsu_hs) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (last_cycle) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    sram_ren       = 1'b0;
    sram_wen       = 1'b0;
    sram_raddr     = '0;
    sram_waddr     = '0;
    sram_wdata     = '0;
    sram_rmask     = 8'h00;
    sram_wmask     = 8'h00;
    case (state)
      IDLE: begin
        // At most one ready, and only to a master that is actually requesting.
        ifu_req_ready = ifu_req_valid & ~grant_lsu;
        lsu_req_ready = lsu_req_valid &  grant_lsu;
      end
      ACCESS: begin
        sram_raddr = addr_q;
        sram_waddr = addr_q;
        sram_wdata = wdata_q;
        sram_ren   = ~wen_q;
        // A store is issued once, on the final access cycle, so a multi-cycle
        // latency never writes the SRAM more than once.
        sram_wen   = wen_q & last_cycle;
        sram_rmask = wen_q ? 8'h00  : mask_q;
        sram_wmask = wen_q ? mask_q : 8'h00;
      end
      RESP: begin
        ifu_resp_valid = (owner == OWN_IFU);
        lsu_resp_valid = (owner == OWN_LSU);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction latch, latency counter and response data
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner     <= OWN_IFU;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= 8'h00;
      cnt       <= 8'd0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      if (ifu_hs) begin
        owner   <= OWN_IFU;
        wen_q   <= 1'b0;
        addr_q  <= ifu_addr;
        wdata_q <= '0;
        mask_q  <= IFU_MASK;
        cnt     <= CNT_INIT;
      end else if (lsu_hs) begin
        owner   <= OWN_LSU;
        wen_q   <= lsu_wen;
        addr_q  <= lsu_addr;
        wdata_q <= lsu_wdata;
        mask_q  <= lsu_mask;
        cnt     <= CNT_INIT;
      end else if (state == ACCESS) begin
        if (last_cycle) begin
          // Response data is captured once and then held through RESP.
          if (owner == OWN_IFU) begin
            ifu_rdata <= sram_rdata;
          end else begin
            lsu_rdata <= wen_q ? '0 : sram_rdata;
          end
        end else begin
          cnt <= cnt - 8'd1;
        end
      end
    end
  end

`ifdef ARB_RR_EN
  // Winner of the most recent request handshake; starts as LSU so IFU wins
  // the first tie after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= OWN_LSU;
    end else if (ifu_hs) begin
      last_grant <= OWN_IFU;
    end else if (lsu_hs) begin
      last_grant <= OWN_LSU;
    end
  end
`endif

endmodule
